// File: rtl/priority_encoder4to2.sv
// Registered 4:2 priority encoder: request pulses queue in pend, one 2-bit code is emitted per transfer.
// Latency: request at edge N shows in pend after N, in Y/valid after N+1; ready=0 holds Y/valid while pend keeps accumulating.
module priority_encoder4to2 #(
  parameter int PRIORITY_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] D,
  output logic [1:0] Y,
  output logic       valid,
  input  logic       ready,
  output logic [3:0] pend,
  output logic       dup
);

  logic [3:0] pend_q, pend_d;
  logic [1:0] y_q, y_d;
  logic       valid_q, valid_d;
  logic       dup_q, dup_d;

  logic       slot_free;
  logic       load;
  logic [1:0] sel_idx;
  logic [3:0] clr_mask;
  logic [3:0] req;

  // Selection looks only at registered pend, so D can never reach Y in the same cycle.
  always_comb begin
    sel_idx = 2'd0;
    if (PRIORITY_HIGH != 0) begin
      if (pend_q[3])      sel_idx = 2'd3;
      else if (pend_q[2]) sel_idx = 2'd2;
      else if (pend_q[1]) sel_idx = 2'd1;
      else                sel_idx = 2'd0;
    end else begin
      if (pend_q[0])      sel_idx = 2'd0;
      else if (pend_q[1]) sel_idx = 2'd1;
      else if (pend_q[2]) sel_idx = 2'd2;
      else                sel_idx = 2'd3;
    end
  end

  always_comb begin
    slot_free = !valid_q || ready;
    load      = slot_free && (pend_q != 4'b0000);
    clr_mask  = load ? (4'b0001 << sel_idx) : 4'b0000;
    req       = en ? D : 4'b0000;

    pend_d  = (pend_q & ~clr_mask) | req;
    // A bit cleared and re-requested on one edge is a fresh request, hence ~clr_mask.
    dup_d   = |(req & pend_q & ~clr_mask);
    valid_d = slot_free ? (pend_q != 4'b0000) : valid_q;
    y_d     = load ? sel_idx : y_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 4'b0000;
      y_q     <= 2'b00;
      valid_q <= 1'b0;
      dup_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      dup_q   <= dup_d;
    end
  end

  assign Y     = y_q;
  assign valid = valid_q;
  assign pend  = pend_q;
  assign dup   = dup_q;

endmodule

// File: tb/tb_priority_encoder4to2.sv
// Bench for priority_encoder4to2: instance 0 uses PRIORITY_HIGH=1, instance 1 uses PRIORITY_HIGH=0.
module tb_priority_encoder4to2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] D;
  logic       ready;

  logic [1:0] y_w     [2];
  logic       valid_w [2];
  logic [3:0] pend_w  [2];
  logic       dup_w   [2];

  // Reference model state, one per instance
  logic [3:0] m_pend  [2];
  logic [1:0] m_y     [2];
  logic       m_valid [2];
  logic       m_dup   [2];

  int n_chk;
  int n_fail;

  priority_encoder4to2 #(.PRIORITY_HIGH(1)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .D(D), .Y(y_w[0]), .valid(valid_w[0]),
    .ready(ready), .pend(pend_w[0]), .dup(dup_w[0])
  );

  priority_encoder4to2 #(.PRIORITY_HIGH(0)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .D(D), .Y(y_w[1]), .valid(valid_w[1]),
    .ready(ready), .pend(pend_w[1]), .dup(dup_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 4'b0000; m_y[k] = 2'b00; m_valid[k] = 1'b0; m_dup[k] = 1'b0;
    end
  endtask

  // Advance one clock edge; the model walks the requests in priority order as a set.
  task automatic tick();
    logic [3:0] np [2];
    logic [1:0] ny [2];
    logic       nv [2];
    logic       nd [2];
    for (int k = 0; k < 2; k++) begin
      int         pick;
      bit         free;
      logic [3:0] taken;
      pick  = -1;
      taken = 4'b0000;
      free  = !m_valid[k] || ready;
      for (int j = 0; j < 4; j++) begin
        int b;
        b = (k == 0) ? 3 - j : j;
        if (pick < 0 && m_pend[k][b]) pick = b;
      end
      if (free && pick >= 0) taken[pick] = 1'b1;
      np[k] = m_pend[k];
      ny[k] = m_y[k];
      nv[k] = m_valid[k];
      nd[k] = 1'b0;
      for (int b = 0; b < 4; b++) begin
        bit was, req;
        was = m_pend[k][b] && !taken[b];
        req = en && D[b];
        np[k][b] = was || req;
        if (was && req) nd[k] = 1'b1;
      end
      if (free) begin
        nv[k] = (pick >= 0);
        if (pick >= 0) ny[k] = 2'(pick);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_pend[k] = 4'b0000; m_y[k] = 2'b00; m_valid[k] = 1'b0; m_dup[k] = 1'b0;
      end else begin
        m_pend[k] = np[k]; m_y[k] = ny[k]; m_valid[k] = nv[k]; m_dup[k] = nd[k];
      end
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      en = 1'($urandom); D = 4'($urandom); ready = 1'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if ({pend_w[k], valid_w[k], y_w[k], dup_w[k]} !== 8'h00) begin
          n_fail++;
          $display("FAIL reset_initial dut%0d step%0d: got %b required 00000000", k, s,
                   {pend_w[k], valid_w[k], y_w[k], dup_w[k]});
        end
      end
    end
    #1 rst_n = 1'b1;
    en = 1'b1; ready = 1'b0; D = 4'b1000;
    tick();
    D = 4'b1010;
    tick();
    n_chk++;
    if ({pend_w[0], valid_w[0], y_w[0]} !== 7'b1010_1_11) begin
      n_fail++;
      $display("FAIL reset_preload: got %b required 1010111", {pend_w[0], valid_w[0], y_w[0]});
    end
    D = 4'b0000;
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if ({pend_w[k], valid_w[k], y_w[k], dup_w[k]} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_async dut%0d: got %b required 00000000", k,
                 {pend_w[k], valid_w[k], y_w[k], dup_w[k]});
      end
    end
    for (int s = 0; s < 3; s++) begin
      en = 1'b1; D = 4'($urandom); ready = 1'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if ({pend_w[k], valid_w[k], y_w[k], dup_w[k]} !== 8'h00) begin
          n_fail++;
          $display("FAIL reset_hold dut%0d step%0d: got %b required 00000000", k, s,
                   {pend_w[k], valid_w[k], y_w[k], dup_w[k]});
        end
      end
    end
    en = 1'b0; D = 4'b0000; ready = 1'b1;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [6:0] exp [3];
    exp = '{7'b0100_0_00, 7'b0000_1_10, 7'b0000_0_10};
    ready = 1'b1; en = 1'b1;
    for (int s = 0; s < 3; s++) begin
      D = (s == 0) ? 4'b0100 : 4'b0000;
      tick();
      n_chk++;
      if ({pend_w[0], valid_w[0], y_w[0]} !== exp[s]) begin
        n_fail++;
        $display("FAIL single step%0d: got %b required %b", s, {pend_w[0], valid_w[0], y_w[0]}, exp[s]);
      end
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if ({pend_w[k], valid_w[k], y_w[k], dup_w[k]} !== {m_pend[k], m_valid[k], m_y[k], m_dup[k]}) begin
          n_fail++;
          $display("FAIL single_model dut%0d step%0d: got %b required %b", k, s,
                   {pend_w[k], valid_w[k], y_w[k], dup_w[k]}, {m_pend[k], m_valid[k], m_y[k], m_dup[k]});
        end
      end
    end
  endtask

  task automatic test_multi_drain();
    logic [6:0] exp [2][5];
    exp[0] = '{7'b1011_0_10, 7'b0011_1_11, 7'b0001_1_01, 7'b0000_1_00, 7'b0000_0_00};
    exp[1] = '{7'b1011_0_10, 7'b1010_1_00, 7'b1000_1_01, 7'b0000_1_11, 7'b0000_0_11};
    ready = 1'b1; en = 1'b1;
    for (int s = 0; s < 5; s++) begin
      D = (s == 0) ? 4'b1011 : 4'b0000;
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if ({pend_w[k], valid_w[k], y_w[k]} !== exp[k][s]) begin
          n_fail++;
          $display("FAIL multi_drain dut%0d step%0d: got %b required %b", k, s,
                   {pend_w[k], valid_w[k], y_w[k]}, exp[k][s]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [6:0] exp [2][9];
    exp[0] = '{7'b0110_0_00, 7'b0010_1_10, 7'b0010_1_10, 7'b0010_1_10, 7'b0010_1_10,
               7'b0010_1_10, 7'b0010_1_10, 7'b0000_1_01, 7'b0000_0_01};
    exp[1] = '{7'b0110_0_11, 7'b0100_1_01, 7'b0100_1_01, 7'b0100_1_01, 7'b0100_1_01,
               7'b0100_1_01, 7'b0100_1_01, 7'b0000_1_10, 7'b0000_0_10};
    en = 1'b1;
    for (int s = 0; s < 9; s++) begin
      D     = (s == 0) ? 4'b0110 : 4'b0000;
      ready = (s >= 7);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if ({pend_w[k], valid_w[k], y_w[k]} !== exp[k][s]) begin
          n_fail++;
          $display("FAIL backpressure dut%0d step%0d: got %b required %b", k, s,
                   {pend_w[k], valid_w[k], y_w[k]}, exp[k][s]);
        end
      end
    end
  endtask

  task automatic test_enable_dup();
    logic       en_t  [11];
    logic [3:0] d_t   [11];
    logic       rdy_t [11];
    logic [7:0] exp   [11];
    int         zero_xfers;
    en_t  = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    d_t   = '{4'b1000, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b0001, 4'b0001,
              4'b0000, 4'b0000, 4'b0000, 4'b0000};
    rdy_t = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    exp   = '{8'b1000_0_01_0, 8'b0000_1_11_0, 8'b0000_1_11_0, 8'b0000_1_11_0, 8'b0000_1_11_0,
              8'b0001_1_11_0, 8'b0001_1_11_1, 8'b0001_1_11_0, 8'b0000_1_00_0, 8'b0000_0_00_0,
              8'b0000_0_00_0};
    zero_xfers = 0;
    for (int s = 0; s < 11; s++) begin
      en = en_t[s]; D = d_t[s]; ready = rdy_t[s];
      if (valid_w[0] && ready && y_w[0] == 2'b00) zero_xfers++;
      tick();
      n_chk++;
      if ({pend_w[0], valid_w[0], y_w[0], dup_w[0]} !== exp[s]) begin
        n_fail++;
        $display("FAIL enable_dup step%0d: got %b required %b", s,
                 {pend_w[0], valid_w[0], y_w[0], dup_w[0]}, exp[s]);
      end
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if ({pend_w[k], valid_w[k], y_w[k], dup_w[k]} !== {m_pend[k], m_valid[k], m_y[k], m_dup[k]}) begin
          n_fail++;
          $display("FAIL enable_dup_model dut%0d step%0d: got %b required %b", k, s,
                   {pend_w[k], valid_w[k], y_w[k], dup_w[k]}, {m_pend[k], m_valid[k], m_y[k], m_dup[k]});
        end
      end
    end
    n_chk++;
    if (zero_xfers != 1) begin
      n_fail++;
      $display("FAIL enable_dup_count: got %0d transfers of Y=00, required 1", zero_xfers);
    end
  endtask

  task automatic test_collision();
    logic [7:0] exp [4];
    int         xfers;
    exp   = '{8'b0100_0_00_0, 8'b0100_1_10_0, 8'b0000_1_10_0, 8'b0000_0_10_0};
    xfers = 0;
    en = 1'b1; ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      D = (s < 2) ? 4'b0100 : 4'b0000;
      if (valid_w[0] && y_w[0] == 2'b10) xfers++;
      tick();
      n_chk++;
      if ({pend_w[0], valid_w[0], y_w[0], dup_w[0]} !== exp[s]) begin
        n_fail++;
        $display("FAIL collision step%0d: got %b required %b", s,
                 {pend_w[0], valid_w[0], y_w[0], dup_w[0]}, exp[s]);
      end
    end
    n_chk++;
    if (xfers != 2) begin
      n_fail++;
      $display("FAIL collision_count: got %0d transfers of Y=10, required 2", xfers);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 400; s++) begin
      en    = ($urandom_range(0, 3) != 0);
      D     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      ready = ($urandom_range(0, 2) != 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if ({pend_w[k], valid_w[k], y_w[k], dup_w[k]} !== {m_pend[k], m_valid[k], m_y[k], m_dup[k]}) begin
          n_fail++;
          $display("FAIL random dut%0d step%0d: got %b required %b", k, s,
                   {pend_w[k], valid_w[k], y_w[k], dup_w[k]}, {m_pend[k], m_valid[k], m_y[k], m_dup[k]});
        end
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    D      = 4'b0000;
    ready  = 1'b0;
    model_clear();
    test_reset();
    test_single();
    test_multi_drain();
    test_backpressure();
    test_enable_dup();
    test_collision();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_encoder4to2.md
# priority_encoder4to2

Registered 4-to-2 priority encoder with request queueing and a valid/ready output handshake. It is the sending-side counterpart of the 2:4 decoder. Single-cycle request pulses on a 4-bit line are captured into a pending register. They are then emitted one at a time as 2-bit codes, highest priority first. Downstream logic, typically a 2:4 decoder, consumes one code per accepted transfer.

## Interface
Parameters:
- PRIORITY_HIGH, default 1: 1 = bit 3 has highest priority; 0 = bit 0 has highest priority.

Ports:
- clk  input  1  rising-edge clock; one clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  capture enable; when 0, D is ignored.
- D  input  4  request bits, sampled every rising edge while en=1; multi-hot allowed.
- Y  output  2  encoded index of the granted request; registered.
- valid  output  1  Y holds a code not yet accepted downstream.
- ready  input  1  downstream accepts Y on an edge where valid=1 and ready=1 (a transfer).
- pend  output  4  pending-request register; bit i set = request i captured, not yet loaded into Y.
- dup  output  1  one-cycle registered pulse flagging a request that merged into an already-pending bit.

## Operation
- Output slot states:
  - EMPTY (valid=0).
  - FULL (valid=1).
- Slot is free on an edge when valid=0 or a transfer occurs.
- Load on a free edge with pend≠0:
  - Y ← index of the highest-priority set bit of the current pend.
  - valid ← 1.
  - clr_mask ← one-hot of that index; otherwise clr_mask=0.
- Free edge with pend=0: valid ← 0; Y keeps its last value.
- FULL with ready=0: Y and valid hold; pend only accumulates.
- Pending update on every edge: pend ← (pend & ~clr_mask) | (en ? D : 4'b0000).
- Selection uses registered pend only. D never bypasses to Y in the same cycle.
- Same bit cleared and requested on one edge: bit ends set. This is a new request, not a duplicate.
- dup ← en & |(D & pend & ~clr_mask); the merged request is lost, one code covers both.
- Encoding: Y = binary index 0..3 of the selected bit. Encoding is independent of PRIORITY_HIGH; the parameter changes selection order only.

## Timing
- Reset (rst_n=0, asynchronous, immediate): pend=0000, Y=00, valid=0, dup=0.
  - Mid-operation reset drops all pending and in-flight codes.
  - First load possible on the second edge after rst_n rises and a request is captured.
- Latency, EMPTY slot:
  - D sampled at edge N.
  - pend bit visible after N.
  - valid=1 with Y after edge N+1.
- Throughput: one code per cycle while ready=1 and pend≠0. Transfer and reload happen on the same edge, so valid stays high.
- Y and valid change only on clock edges or reset. Y is stable for the whole time valid=1 and ready=0.
- dup asserts for exactly the cycle after the offending edge.
- ready while valid=0 has no effect.

## Test plan
1. Reset: assert rst_n=0 mid-cycle with pend=1010, valid=1 → immediately pend=0000, Y=00, valid=0, dup=0; all outputs stay there while rst_n=0.
2. Single request, PRIORITY_HIGH=1, ready=1: D=0100 for one edge → pend=0100 after edge 1; valid=1, Y=10, pend=0000 after edge 2; valid=0 after edge 3.
3. Multi-hot drain, PRIORITY_HIGH=1, ready=1: D=1011 for one edge → Y sequence 11, 01, 00 on three consecutive cycles with valid high, pend 0011→0001→0000; valid=0 on the next edge. With PRIORITY_HIGH=0 the order is 00, 01, 11.
4. Backpressure: ready=0, D=0110 once → Y=10 held with valid=1 and pend=0010 for ≥5 cycles. Raise ready → Y=01 next cycle; valid=0 one cycle later.
5. Enable and duplicate:
   - en=0, D=1111 for 3 edges → pend, Y and valid unchanged.
   - Then en=1, ready=0, D=0001 on two edges while bit 0 is pending → dup=1 for one cycle.
   - Draining then yields exactly one Y=00.
6. Same-edge collision: D=0100 asserted on the edge where bit 2 is loaded into Y → pend bit 2 remains set, dup=0, and a second Y=10 follows.
